// File: rtl/instr_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them to
// instruction memory, then releases the CPU. Optional trailing checksum: INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned data_size    = 32,
  parameter int unsigned address_size = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [address_size:0]   i_num_words,
  input  logic [7:0]              i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [31:0]             o_mem_address,
  output logic [data_size-1:0]    o_mem_data_in,
  output logic                    o_mem_write,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_cpu_run,
  output logic                    o_chk_err
);

  localparam int unsigned BYTES = data_size / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IDX_W = address_size + 1;
  localparam logic [IDX_W-1:0] DEPTH     = IDX_W'(2 ** address_size);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_END     = S_CHECK;
`else
  localparam logic [2:0] S_END     = S_DONE;
`endif

  logic [2:0]           r_state;
  logic [2:0]           w_state_nx;
  logic                 w_load;
  logic [IDX_W-1:0]     r_index;
  logic [IDX_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [data_size-1:0] r_word;
  logic [31:0]          r_mem_address;
  logic                 r_in_ready;
  logic                 r_mem_write;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cpu_run;

  logic                 w_accept;
  logic                 w_last_byte;
  logic [IDX_W-1:0]     w_index_inc;
  logic [IDX_W-1:0]     w_clamped;

  assign w_accept    = r_in_ready & i_in_valid;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_index_inc = r_index + IDX_W'(1);
  assign w_clamped   = (i_num_words > DEPTH) ? DEPTH : i_num_words;

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_load     = 1'b1;
          w_state_nx = (w_clamped == '0) ? S_END : S_COLLECT;
        end
      end
      S_COLLECT: if (w_accept && w_last_byte) w_state_nx = S_WRITE;
      S_WRITE:   w_state_nx = (w_index_inc == r_count) ? S_END : S_COLLECT;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK:   if (w_accept) w_state_nx = S_DONE;
`endif
      default:   w_state_nx = S_IDLE;
    endcase
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_chk_err;
  logic       w_ready_nx;
  logic       w_busy_nx;
  assign w_ready_nx = (w_state_nx == S_COLLECT) || (w_state_nx == S_CHECK);
  assign w_busy_nx  = w_ready_nx || (w_state_nx == S_WRITE);
  assign o_chk_err  = r_chk_err;

  // Running byte sum and verdict on the trailing checksum byte
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum     <= 8'h00;
      r_chk_err <= 1'b0;
    end else if (w_load) begin
      r_sum     <= 8'h00;
      r_chk_err <= 1'b0;
    end else if (r_state == S_COLLECT && w_accept) begin
      r_sum <= r_sum + i_in_data;
    end else if (r_state == S_CHECK && w_accept) begin
      r_chk_err <= (i_in_data != r_sum);
    end
  end
`else
  logic w_ready_nx;
  logic w_busy_nx;
  assign w_ready_nx = (w_state_nx == S_COLLECT);
  assign w_busy_nx  = w_ready_nx || (w_state_nx == S_WRITE);
  assign o_chk_err  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_count       <= '0;
      r_byte_cnt    <= '0;
      r_word        <= '0;
      r_mem_address <= 32'h0;
      r_in_ready    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cpu_run     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= w_ready_nx;
      r_busy      <= w_busy_nx;
      r_mem_write <= (w_state_nx == S_WRITE);
      if (w_load) begin
        r_count    <= w_clamped;
        r_index    <= '0;
        r_byte_cnt <= '0;
        r_done     <= 1'b0;
        r_cpu_run  <= 1'b0;
      end
      if (r_state == S_COLLECT && w_accept) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= i_in_data;
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CNT_W'(1);
        if (w_last_byte) r_mem_address <= 32'({r_index, 2'b00});
      end
      if (r_state == S_WRITE) r_index <= w_index_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (r_state == S_CHECK && w_accept) begin
        r_done    <= 1'b1;
        r_cpu_run <= (i_in_data == r_sum);
      end
`else
      if (w_state_nx == S_DONE && (r_state != S_DONE || w_load)) begin
        r_done    <= 1'b1;
        r_cpu_run <= 1'b1;
      end
`endif
    end
  end

  // Strobe is gated by reset so a write in flight is dropped on the reset edge
  assign o_mem_write   = r_mem_write & i_rst_n;
  assign o_in_ready    = r_in_ready;
  assign o_mem_address = r_mem_address;
  assign o_mem_data_in = r_word;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cpu_run     = r_cpu_run;

endmodule
